// File: rtl/cr_kme_pkg.sv
// ---------------------------------------------------------------------------
// cr_kme_pkg
//   Types and constants shared by the KME core glue, the register block and
//   the idle_t packing:
//     kme_idle_state_e   idle qualification FSM encoding
//     ERR_*_BIT          bit positions inside err_sticky
//     KME_N_END/CNT_W    default end-source count and in-flight counter width
// ---------------------------------------------------------------------------
package cr_kme_pkg;

    typedef enum logic [1:0] {
        BUSY = 2'd0,
        QUAL = 2'd1,
        IDLE = 2'd2
    } kme_idle_state_e;

    localparam int ERR_UNDERFLOW_BIT = 0;
    localparam int ERR_OVERFLOW_BIT  = 1;

    localparam int KME_N_END = 8;
    localparam int KME_CNT_W = 20;

endpackage : cr_kme_pkg

// File: rtl/cr_kme_popcount.sv
// ---------------------------------------------------------------------------
// cr_kme_popcount
//   Combinational population count of an N-bit vector.
//   Ports:
//     bits   in  [N-1:0]             vector to count
//     count  out [$clog2(N+1)-1:0]   number of set bits
// ---------------------------------------------------------------------------
module cr_kme_popcount #(
    parameter int N = 8
) (
    input  logic [N-1:0]             bits,
    output logic [$clog2(N+1)-1:0]   count
);

    localparam int W = $clog2(N + 1);

    // NOTE: every combinational output gets a default before any conditional
    // or loop update, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        count = '0;
        for (int i = 0; i < N; i++) begin
            count = count + W'(bits[i]);
        end
    end

endmodule : cr_kme_popcount

// File: rtl/cr_kme_inflight_idle_mon.sv
// ---------------------------------------------------------------------------
// cr_kme_inflight_idle_mon
//   Counts key TLVs in flight (all simultaneous start/end pulses are summed),
//   flags underflow/overflow, tracks a high-water mark and qualifies kme_idle
//   through a programmable hold-off FSM.
//   Ports:
//     clk, rst_n          core clock, synchronous active-low reset
//     start_pulse         [N_START] one-cycle TLV-start pulses
//     end_pulse           [N_END]   one-cycle TLV-complete pulses
//     comp_idle           [N_IDLE]  sub-block idle levels
//     force_busy          register override, holds kme_idle low
//     idle_hold_cfg       [HOLD_W]  extra cycles raw idle must persist
//     err_clear           level; rising edge clears err_sticky
//     hwm_clear           level; rising edge reloads inflight_hwm
//     inflight_cnt        [CNT_W]   current in-flight count
//     no_inflight         inflight_cnt == 0
//     inflight_hwm        [CNT_W]   high-water mark
//     kme_idle            qualified idle
//     set_underflow_int   one-cycle interrupt set pulse
//     set_overflow_int    one-cycle interrupt set pulse
//     err_sticky          [2] {overflow, underflow}
// ---------------------------------------------------------------------------
module cr_kme_inflight_idle_mon
    import cr_kme_pkg::*;
#(
    parameter int N_START = 1,
    parameter int N_END   = KME_N_END,
    parameter int N_IDLE  = 11,
    parameter int CNT_W   = KME_CNT_W,
    parameter int HOLD_W  = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_START-1:0]  start_pulse,
    input  logic [N_END-1:0]    end_pulse,
    input  logic [N_IDLE-1:0]   comp_idle,
    input  logic                force_busy,
    input  logic [HOLD_W-1:0]   idle_hold_cfg,
    input  logic                err_clear,
    input  logic                hwm_clear,
    output logic [CNT_W-1:0]    inflight_cnt,
    output logic                no_inflight,
    output logic [CNT_W-1:0]    inflight_hwm,
    output logic                kme_idle,
    output logic                set_underflow_int,
    output logic                set_overflow_int,
    output logic [1:0]          err_sticky
);

    localparam int S_W   = $clog2(N_START + 1);
    localparam int E_W   = $clog2(N_END + 1);
    localparam int SUM_W = CNT_W + 1;
    localparam logic [SUM_W-1:0] CNT_MAX = {1'b0, {CNT_W{1'b1}}};

    // ------------------------------------------------------------------
    // Pulse counting
    // ------------------------------------------------------------------
    logic [S_W-1:0] start_cnt;
    logic [E_W-1:0] end_cnt;

    cr_kme_popcount #(.N(N_START)) u_start_pop (
        .bits  (start_pulse),
        .count (start_cnt)
    );

    cr_kme_popcount #(.N(N_END)) u_end_pop (
        .bits  (end_pulse),
        .count (end_cnt)
    );

    logic [SUM_W-1:0] base;
    logic [SUM_W-1:0] diff;
    logic [SUM_W-1:0] e_ext;
    logic             underflow;
    logic             overflow;
    logic [CNT_W-1:0] cnt_next;

    always_comb begin
        e_ext     = SUM_W'(end_cnt);
        base      = {1'b0, inflight_cnt} + SUM_W'(start_cnt);
        diff      = base - e_ext;
        underflow = (base < e_ext);
        overflow  = !underflow && (diff > CNT_MAX);
        if (underflow) begin
            cnt_next = '0;
        end else if (overflow) begin
            cnt_next = '1;
        end else begin
            cnt_next = diff[CNT_W-1:0];
        end
    end

    // ------------------------------------------------------------------
    // Register-level edge detection, sticky errors, high-water mark
    // ------------------------------------------------------------------
    logic       err_clear_q;
    logic       hwm_clear_q;
    logic       err_clear_rise;
    logic       hwm_clear_rise;
    logic [1:0] err_next;
    logic [CNT_W-1:0] hwm_next;

    assign err_clear_rise = err_clear & ~err_clear_q;
    assign hwm_clear_rise = hwm_clear & ~hwm_clear_q;

    // A clear and a fresh error in the same cycle: the error is kept.
    always_comb begin
        err_next = err_sticky;
        if (err_clear_rise) begin
            err_next = '0;
        end
        if (underflow) begin
            err_next[ERR_UNDERFLOW_BIT] = 1'b1;
        end
        if (overflow) begin
            err_next[ERR_OVERFLOW_BIT] = 1'b1;
        end
    end

    always_comb begin
        if (hwm_clear_rise) begin
            hwm_next = cnt_next;
        end else if (cnt_next > inflight_hwm) begin
            hwm_next = cnt_next;
        end else begin
            hwm_next = inflight_hwm;
        end
    end

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples values from before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            inflight_cnt      <= '0;
            inflight_hwm      <= '0;
            err_sticky        <= '0;
            set_underflow_int <= 1'b0;
            set_overflow_int  <= 1'b0;
            err_clear_q       <= 1'b0;
            hwm_clear_q       <= 1'b0;
        end else begin
            inflight_cnt      <= cnt_next;
            inflight_hwm      <= hwm_next;
            err_sticky        <= err_next;
            set_underflow_int <= underflow;
            set_overflow_int  <= overflow;
            err_clear_q       <= err_clear;
            hwm_clear_q       <= hwm_clear;
        end
    end

    assign no_inflight = (inflight_cnt == '0);

    // ------------------------------------------------------------------
    // Idle qualification FSM
    // ------------------------------------------------------------------
    // raw_idle looks at the registered count, so a start pulse is caught
    // directly here one cycle before the count itself moves.
    logic            raw_idle;
    kme_idle_state_e state;
    kme_idle_state_e state_next;
    logic [HOLD_W-1:0] timer;
    logic [HOLD_W-1:0] timer_next;

    assign raw_idle = (&comp_idle) & no_inflight & ~(|start_pulse) & ~force_busy;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= BUSY;
            timer <= '0;
        end else begin
            state <= state_next;
            timer <= timer_next;
        end
    end

    // The hold-off configuration is captured only when entering QUAL.
    always_comb begin
        state_next = state;
        timer_next = timer;
        case (state)
            BUSY: begin
                if (raw_idle) begin
                    if (idle_hold_cfg == '0) begin
                        state_next = IDLE;
                    end else begin
                        state_next = QUAL;
                        timer_next = idle_hold_cfg - 1'b1;
                    end
                end
            end
            QUAL: begin
                if (!raw_idle) begin
                    state_next = BUSY;
                end else if (timer == '0) begin
                    state_next = IDLE;
                end else begin
                    timer_next = timer - 1'b1;
                end
            end
            IDLE: begin
                if (!raw_idle) begin
                    state_next = BUSY;
                end
            end
            default: begin
                state_next = BUSY;
            end
        endcase
    end

    assign kme_idle = (state == IDLE);

endmodule : cr_kme_inflight_idle_mon

// File: doc/cr_kme_inflight_idle_mon.md
# cr_kme_inflight_idle_mon

Parametrised successor to the KME core-glue idle logic. It tracks key TLVs in flight across any number of start and end channels, counting all simultaneous pulses rather than OR-reducing them. It detects counter underflow and overflow, keeps a high-water mark, and qualifies `kme_idle` through a programmable hold-off state machine. It sits in `cr_kme_core` between the TLV parser / key-TLV RSMs and the register block.

## Interface
Parameters:
- `N_START`, 1: number of TLV-start pulse sources.
- `N_END`, 8: number of key-TLV RSM end-pulse sources (4 CCEIP + 4 CDDIP).
- `N_IDLE`, 11: number of component idle inputs ANDed into `kme_idle`.
- `CNT_W`, 20: in-flight counter and high-water-mark width.
- `HOLD_W`, 8: idle hold-off configuration width.

Ports:
- `clk` in 1: core clock; single clock domain.
- `rst_n` in 1: reset, synchronous and active-low.
- `start_pulse` in `N_START`: one-cycle TLV-start pulses.
- `end_pulse` in `N_END`: one-cycle TLV-complete pulses.
- `comp_idle` in `N_IDLE`: level idle indications from sub-blocks.
- `force_busy` in 1: register override; holds `kme_idle` low.
- `idle_hold_cfg` in `HOLD_W`: number of extra cycles `raw_idle` must persist before `kme_idle` asserts.
- `err_clear` in 1: register level; rising edge clears the sticky errors.
- `hwm_clear` in 1: register level; rising edge reloads the high-water mark.
- `inflight_cnt` out `CNT_W`: current in-flight count.
- `no_inflight` out 1: `inflight_cnt == 0`.
- `inflight_hwm` out `CNT_W`: maximum `inflight_cnt` since reset or last clear.
- `kme_idle` out 1: qualified idle.
- `set_underflow_int` out 1: one-cycle interrupt set pulse.
- `set_overflow_int` out 1: one-cycle interrupt set pulse.
- `err_sticky` out 2: {overflow, underflow} sticky status.

## Operation
- Per cycle, S = popcount(`start_pulse`) and E = popcount(`end_pulse`). Both are evaluated at full width, `CNT_W`+1 bits.
- Next count: sum = `inflight_cnt` + S − E.
  - If `inflight_cnt` + S < E: next count is 0; pulse `set_underflow_int`; set `err_sticky[0]`.
  - Else if sum > 2^`CNT_W`−1: next count saturates at 2^`CNT_W`−1; pulse `set_overflow_int`; set `err_sticky[1]`.
  - Else: next count is sum. S == E gives no change.
- High-water mark:
  - `inflight_hwm` <= max(`inflight_hwm`, next count).
  - On a `hwm_clear` rising edge, `inflight_hwm` <= next count instead.
- Sticky errors: an `err_clear` rising edge clears `err_sticky`. If a new error occurs in the same cycle, the set wins.
- Edge detection: `err_clear` and `hwm_clear` each have a one-flop history register; edge = level & ~previous.
- `raw_idle` = &`comp_idle` & `no_inflight` & ~|`start_pulse` & ~`force_busy`. It uses the registered count.
- Idle FSM (2-bit state):
  - BUSY:
    - `raw_idle` and cfg == 0 → IDLE.
    - `raw_idle` and cfg ≠ 0 → QUAL, timer <= cfg − 1.
  - QUAL:
    - ~`raw_idle` → BUSY.
    - timer == 0 → IDLE.
    - Otherwise timer decrements.
  - IDLE: ~`raw_idle` → BUSY.
  - `idle_hold_cfg` is sampled only on the BUSY→QUAL transition. Changes while in QUAL have no effect.
- `kme_idle` = (state == IDLE), decoded from the state register.

## Timing
- Reset values: `inflight_cnt` 0, `inflight_hwm` 0, `err_sticky` 0, interrupts 0, state BUSY, `kme_idle` 0, edge-history flops 0.
  - `no_inflight` is 1 during and after reset.
- Count latency: pulses in cycle t are reflected in `inflight_cnt` in cycle t+1. Interrupt pulses and sticky bits appear in t+1 too.
- `kme_idle` rise latency: `raw_idle` continuously true from cycle t → `kme_idle` high from cycle t+1+cfg.
- `kme_idle` fall latency: `raw_idle` false in cycle t → `kme_idle` low in cycle t+1. A `start_pulse` therefore deasserts idle one cycle later, before the count increments.
- Reset mid-operation: all state returns to reset values on the next edge. In-flight history is lost.
- No handshakes. All inputs are assumed synchronous to `clk`.

## Structure
- Shared package `cr_kme_pkg` holds:
  - `kme_idle_state_e` {BUSY, QUAL, IDLE};
  - the `err_sticky` bit-index localparams;
  - the default `N_END` and `CNT_W` constants, so the register block and `idle_t` packing agree.
- Sub-module `cr_kme_popcount #(N)`: combinational population count with output width $clog2(N+1). It is instantiated twice.
- The rest stays in one module, roughly 200 lines.

## Test plan
- Reset, then 3 cycles each with `start_pulse`=1 and no ends → `inflight_cnt` 1, 2, 3, with `inflight_hwm` tracking it.
- Next, one cycle with `end_pulse`=8'b1010_0101 → count 3 − 4 underflows to 0. `set_underflow_int` pulses once, `err_sticky` = 2'b01, and `inflight_hwm` stays 3.
- `CNT_W`=4, count at 14, S=1 and E=0 for 2 cycles → 15, then stays 15 with `set_overflow_int` pulsed and `err_sticky[1]` set. An `err_clear` rise in the same cycle as a new overflow leaves the bit set.
- `idle_hold_cfg`=3, all `comp_idle` high, count 0 → `kme_idle` rises exactly 4 cycles after `raw_idle`.
- Repeat, dropping one `comp_idle` bit for 1 cycle during QUAL → FSM returns to BUSY and the full 4-cycle count restarts.
- `kme_idle` high, assert `force_busy` for 1 cycle → `kme_idle` low for ≥1 cycle. With cfg=0 it reasserts the cycle after `force_busy` drops.
- Count 5 with `inflight_hwm` 9, `hwm_clear` rise in the same cycle as S=1 → `inflight_hwm` = 6. Holding `hwm_clear` high for further cycles causes no further reloads.
